// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: double-buffered 8-digit multiplexed seven-segment scanner.
// In: CLK, nrst (sync, active-low), value/dp/blank/lz_en, load. Out: seg, seg_dp, an, frame_done, pending.
module sevenseg_scan_driver #(
    parameter int DWELL_CYC      = 50000,
    parameter int GHOST_CYC      = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic        CLK,
    input  logic        nrst,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic [7:0]  blank,
    input  logic        lz_en,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        seg_dp,
    output logic [7:0]  an,
    output logic        frame_done,
    output logic        pending
);

    localparam int CW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] CNT_GHOST = CW'(GHOST_CYC);
    localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_POL  = (AN_ACTIVE_LOW != 0);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;

    logic [31:0] sh_value;
    logic [7:0]  sh_dp;
    logic [7:0]  sh_blank;
    logic        sh_lz;

    logic [31:0] d_value;
    logic [7:0]  d_dp;
    logic [7:0]  d_blank;
    logic        d_lz;

    logic        slot_end;
    logic        boundary;
    logic [3:0]  nib;
    logic [31:0] upper;
    logic        lz_hit;
    logic        drive;
    logic [6:0]  seg_hi;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;
    logic [7:0]  an_nxt;

    assign slot_end = (cnt == CNT_LAST);
    assign boundary = slot_end && (idx == 3'd7);

    // Digit selected by the current scan state; outputs are registered from it.
    always_comb begin
        nib    = d_value[{idx, 2'b00} +: 4];
        upper  = d_value >> {idx, 2'b00};
        // A lit decimal point keeps an otherwise-suppressed zero visible.
        lz_hit = d_lz && (idx != 3'd0) && (upper == 32'd0) && !d_dp[idx];
        drive  = (cnt >= CNT_GHOST) && !d_blank[idx] && !lz_hit;
    end

    always_comb begin
        seg_hi = 7'h00;
        unique case (nib)
            4'h0: seg_hi = 7'h3F;
            4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;
            4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;
            4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;
            4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;
            4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;
            4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;
            4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;
            4'hF: seg_hi = 7'h71;
        endcase
    end

    // Polarity is applied by XOR so the off level follows the parameters.
    always_comb begin
        seg_nxt = (drive ? seg_hi : 7'h00) ^ {7{SEG_POL}};
        dp_nxt  = (drive && d_dp[idx]) ^ SEG_POL;
        an_nxt  = (drive ? (8'd1 << idx) : 8'd0) ^ {8{AN_POL}};
    end

    always_ff @(posedge CLK) begin
        if (!nrst) begin
            cnt        <= '0;
            idx        <= 3'd0;
            sh_value   <= 32'd0;
            sh_dp      <= 8'd0;
            sh_blank   <= 8'd0;
            sh_lz      <= 1'b0;
            d_value    <= 32'd0;
            d_dp       <= 8'd0;
            d_blank    <= 8'd0;
            d_lz       <= 1'b0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            seg        <= {7{SEG_POL}};
            seg_dp     <= SEG_POL;
            an         <= {8{AN_POL}};
        end else begin
            seg        <= seg_nxt;
            seg_dp     <= dp_nxt;
            an         <= an_nxt;
            frame_done <= boundary;

            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (load) begin
                sh_value <= value;
                sh_dp    <= dp;
                sh_blank <= blank;
                sh_lz    <= lz_en;
            end

            // A load landing on the boundary bypasses the shadow stage.
            if (boundary && load) begin
                d_value <= value;
                d_dp    <= dp;
                d_blank <= blank;
                d_lz    <= lz_en;
                pending <= 1'b0;
            end else if (boundary && pending) begin
                d_value <= sh_value;
                d_dp    <= sh_dp;
                d_blank <= sh_blank;
                d_lz    <= sh_lz;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: scoreboard bench for the seven-segment scanner.
// Small dwell (8) and ghost (2) so one frame is 64 cycles.
module tb_sevenseg_scan_driver;

    logic        CLK;
    logic        nrst;
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic        lz_en;
    logic        load;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [7:0]  an;
    logic        frame_done;
    logic        pending;

    sevenseg_scan_driver #(
        .DWELL_CYC(8),
        .GHOST_CYC(2),
        .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW(1)
    ) dut (
        .CLK(CLK),
        .nrst(nrst),
        .value(value),
        .dp(dp),
        .blank(blank),
        .lz_en(lz_en),
        .load(load),
        .seg(seg),
        .seg_dp(seg_dp),
        .an(an),
        .frame_done(frame_done),
        .pending(pending)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b0;
    logic [7:0] prev_an = 8'hFF;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] hexseg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Push one frame of expected driven slots; mask lists the lit digits.
    task automatic push_frame(input logic [31:0] v, input logic [7:0] d,
                              input logic [7:0] mask);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) begin
                e.an  = ~(8'd1 << k);
                e.seg = ~hexseg(v[4*k +: 4]);
                e.dp  = ~d[k];
                q.push_back(e);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_frame(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            if (frame_done === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            checks++;
            failures++;
            $display("FAIL frame_done_timeout actual=none expected=pulse");
        end
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] d,
                           input logic [7:0] b, input logic lz);
        value = v; dp = d; blank = b; lz_en = lz; load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
    endtask

    // Monitor: each slot's first driven cycle is compared against the queue.
    always @(negedge CLK) begin
        exp_t e;
        if (mon_en && an !== 8'hFF && prev_an === 8'hFF) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_digit actual_an=%h seg=%h expected=none",
                         an, seg);
            end else begin
                e = q.pop_front();
                if (an !== e.an || seg !== e.seg || seg_dp !== e.dp) begin
                    failures++;
                    $display("FAIL slot actual an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                             an, seg, seg_dp, e.an, e.seg, e.dp);
                end
            end
        end
        prev_an = an;
    end

    initial begin
        int n;
        nrst = 1'b0; value = 32'd0; dp = 8'd0; blank = 8'd0;
        lz_en = 1'b0; load = 1'b0;

        repeat (5) @(negedge CLK);
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", seg_dp, 1'b1);
        chk("rst_pending", pending, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        nrst = 1'b1;
        @(negedge CLK);
        chk("ghost0_an", an, 8'hFF);
        @(negedge CLK);
        chk("ghost1_an", an, 8'hFF);
        @(negedge CLK);
        chk("first_an", an, 8'hFE);
        chk("first_seg", seg, 7'h40);
        chk("first_dp", seg_dp, 1'b1);

        // Decode and scan order.
        do_load(32'h89ABCDEF, 8'h01, 8'h00, 1'b0);
        chk("load_pending", pending, 1'b1);
        wait_frame(n);
        chk("boundary_pending", pending, 1'b0);
        push_frame(32'h89ABCDEF, 8'h01, 8'hFF);
        mon_en = 1'b1;
        wait_frame(n);
        chk("frame_period", n, 64);

        // Mid-frame load: old value completes this frame.
        push_frame(32'h89ABCDEF, 8'h01, 8'hFF);
        repeat (24) @(negedge CLK);
        do_load(32'h11111111, 8'h00, 8'h00, 1'b0);
        chk("db_pending1", pending, 1'b1);
        wait_frame(n);
        chk("db_applied1", pending, 1'b0);
        push_frame(32'h11111111, 8'h00, 8'hFF);

        // Two loads in one frame: only the last is shown.
        repeat (16) @(negedge CLK);
        do_load(32'h33333333, 8'h00, 8'h00, 1'b0);
        repeat (23) @(negedge CLK);
        do_load(32'h22222222, 8'h00, 8'h00, 1'b0);
        chk("db_pending2", pending, 1'b1);
        wait_frame(n);
        chk("db_applied2", pending, 1'b0);
        push_frame(32'h22222222, 8'h00, 8'hFF);

        // Load on the boundary cycle goes straight to display.
        repeat (63) @(negedge CLK);
        chk("coll_pre_pending", pending, 1'b0);
        do_load(32'h00000050, 8'h00, 8'h00, 1'b1);
        chk("coll_frame_done", frame_done, 1'b1);
        chk("coll_pending", pending, 1'b0);
        push_frame(32'h00000050, 8'h00, 8'h03);
        repeat (3) @(negedge CLK);
        chk("coll_pending_late", pending, 1'b0);

        // dp overrides suppression of digit 2.
        repeat (5) @(negedge CLK);
        do_load(32'h00000050, 8'h04, 8'h00, 1'b1);
        wait_frame(n);
        push_frame(32'h00000050, 8'h04, 8'h07);

        // Force-blank digit 0.
        repeat (5) @(negedge CLK);
        do_load(32'h00000050, 8'h04, 8'h01, 1'b1);
        wait_frame(n);
        push_frame(32'h00000050, 8'h04, 8'h06);

        // Reset during digit 5 drive with a load pending.
        repeat (4) @(negedge CLK);
        do_load(32'h12345678, 8'h00, 8'h00, 1'b0);
        chk("mid_pending", pending, 1'b1);
        repeat (38) @(negedge CLK);
        mon_en = 1'b0;
        chk("mid_queue_drained", q.size(), 0);
        nrst = 1'b0;
        @(negedge CLK);
        chk("mid_rst_an", an, 8'hFF);
        chk("mid_rst_pending", pending, 1'b0);
        chk("mid_rst_seg", seg, 7'h7F);
        repeat (2) @(negedge CLK);
        nrst = 1'b1;
        @(negedge CLK);
        chk("rel_ghost0", an, 8'hFF);
        @(negedge CLK);
        chk("rel_ghost1", an, 8'hFF);
        @(negedge CLK);
        chk("rel_an", an, 8'hFE);
        chk("rel_seg", seg, 7'h40);
        wait_frame(n);
        chk("rel_period", n, 61);
        push_frame(32'h00000000, 8'h00, 8'hFF);
        mon_en = 1'b1;
        wait_frame(n);
        mon_en = 1'b0;
        chk("final_queue", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Output-side user I/O block: drives the board's multiplexed 8-digit seven-segment display from a 32-bit hex value supplied by the processor or debug logic. Scans one digit at a time with a programmable per-digit dwell and a ghost-blanking gap. Updates to the displayed value are double-buffered so a frame never shows a mix of old and new digits. Sits alongside the button debouncer as the board-facing front end, clocked by the same 50 MHz CLK.

Parameters:
DWELL_CYC, 50000, clock cycles per digit slot including the ghost gap (1 kHz per digit at 50 MHz); legal range ≥ GHOST_CYC+1.
GHOST_CYC, 500, cycles at the start of each slot with all anodes inactive.
SEG_ACTIVE_LOW, 1, 1 = segment and dp outputs are active-low.
AN_ACTIVE_LOW, 1, 1 = anode outputs are active-low.

Ports:
CLK  input  1  system clock, 50 MHz
nrst  input  1  synchronous active-low reset
value  input  32  hex value; nibble k drives digit k (digit 0 = rightmost)
dp  input  8  decimal point per digit, 1 = lit
blank  input  8  per-digit force-blank, 1 = digit dark
lz_en  input  1  leading-zero suppression enable
load  input  1  single-cycle strobe: capture value/dp/blank/lz_en
seg  output  7  segments {g,f,e,d,c,b,a}, bit 0 = a
seg_dp  output  1  decimal point segment
an  output  8  digit anodes, one-hot when active
frame_done  output  1  one-cycle pulse at the end of digit 7's slot
pending  output  1  a captured load has not yet been applied

Behaviour:
- Reset is synchronous on nrst, active-low, clock CLK. On reset: an = all inactive, seg and seg_dp = inactive, frame_done = 0, pending = 0, slot counter = 0, digit index = 0, shadow and display registers = 0 (value 0, dp 0, blank 0, lz_en 0).
- Reset mid-frame aborts the scan immediately; scanning restarts at digit 0, slot cycle 0, on the first cycle after nrst deasserts.
- Inactive polarity: when SEG_ACTIVE_LOW=1, inactive is 1; otherwise 0. The same rule applies to AN_ACTIVE_LOW for an.
- Slot counter: counts 0 .. DWELL_CYC-1, then wraps to 0 and advances the digit index modulo 8. Width = $clog2(DWELL_CYC).
- Per-slot phases: GHOST while counter < GHOST_CYC, with all anodes inactive and seg/seg_dp inactive. DRIVE otherwise, with an one-hot on the current digit, unless that digit is blanked.
- Blanked digit: anode stays inactive for the whole slot. Blanking sources are blank[k] or leading-zero suppression. Slot timing is unchanged.
- Leading-zero suppression: when display lz_en = 1, digit k is suppressed if k > 0 and every nibble k..7 of the display value is 0. Digit 0 is never suppressed. dp[k] = 1 overrides suppression for digit k.
- Decode is fixed hex (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. seg_dp = dp[k]. Outputs are inverted for active-low.
- All outputs are registered. an/seg change exactly one cycle after the counter/index state that selects them; there are no combinational paths from inputs to outputs.
- Double buffer:
  - load=1 copies value/dp/blank/lz_en into the shadow registers and sets pending=1 on the next edge.
  - At a frame boundary (counter = DWELL_CYC-1 and index = 7), if pending, shadow is copied to display and pending clears.
  - If load coincides with the boundary cycle, the new inputs go directly to display and pending stays 0.
  - A load while already pending overwrites the shadow; only the latest load is shown.
- frame_done pulses high for one cycle, registered, on the cycle after the boundary, i.e. coincident with the first cycle of digit 0.

Test Plan:
- Reset/polarity (DWELL_CYC=8, GHOST_CYC=2, defaults): hold nrst=0 for 5 cycles -> an=FF, seg=7F, seg_dp=1, pending=0, frame_done=0. Release -> an stays FF for 2 cycles, then an=FE with seg=40 (digit 0 = '0', active-low 0x3F inverted).
- Decode/scan: load value=0x89ABCDEF, dp=0x01 -> after next boundary, each slot shows an=FE..7F in order. Digit 0 gives seg=0E (F) with seg_dp=0. Digit 7 gives seg=00 (8). frame_done pulses once every 64 cycles.
- Double buffer: load 0x11111111 mid-frame at digit 3 -> pending=1, digits 3..7 still show the old value; first cycle of digit 0 shows '1' and pending=0. A second load of 0x22222222 before the boundary -> only '2' is ever displayed.
- Boundary collision: assert load exactly on counter=7 of digit 7 -> the new value is shown in the next frame's digit 0, and pending is never 1.
- Leading-zero/blank: value=0x00000050, lz_en=1 -> only digits 0 and 1 are driven, an stays FF during slots 2..7. Add dp=0x04 -> digit 2 is driven with seg=40, seg_dp=0. blank=0x01 -> digit 0 is dark.
- Reset mid-operation: pull nrst low during digit 5's DRIVE phase with pending=1 -> next cycle an=FF and pending=0. After release the scan restarts at digit 0 showing '0'.
